ksa_swap_loop_p: RTL and testbench
==================================

Name: ksa_swap_loop_p

Overview:
- Parametrised RC4 key-scheduling swap loop (KSA second loop) for the S-box RAM. Successor to the fixed 3-byte, 256-entry, 2-cycle-latency version.
- Runs after the S-box is initialised to identity. Permutes S in place through a single-port RAM: for i = 0..N-1, j = j + S[i] + key[i mod KEY_BYTES], then swap S[i] and S[j].
- Adds a start/busy/done handshake and restart. Key length, S-box depth and RAM read latency are parameters.

Parameters:
- KEY_BYTES, 3, secret key length in bytes, legal 1..32.
- ADDR_W, 8, S-box address width, N = 2**ADDR_W entries, legal 2..8.
- RD_LAT, 2, RAM read latency in cycles, legal 1..4.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, one-cycle run request; sampled only in IDLE or DONE.
- key, input, 8*KEY_BYTES, secret key; byte 0 = key[8*KEY_BYTES-1 -: 8], MSB-first.
- busy, output, 1, high from the cycle after start is accepted until DONE is entered.
- done, output, 1, high in DONE; held until the next accepted start.
- addr, output, ADDR_W, RAM address (registered).
- rddata, input, 8, RAM read data.
- wrdata, output, 8, RAM write data (registered).
- wren, output, 1, RAM write enable (registered).

Behaviour:
- Reset (async, rst_n=0): state=IDLE; i=0, j=0, kidx=0; addr=0, wrdata=0, wren=0, busy=0, done=0. Applies immediately, including mid-run. The RAM contents are then undefined for the run; a new start is required.
- Memory timing contract: addr is set at clock edge E. rddata for that address is sampled at edge E+RD_LAT+1.
- IDLE/DONE + start=1: latch key into an internal register; clear i, j and kidx; set busy=1 and done=0; go to ISSUE_I. start is ignored in all other states.
- ISSUE_I: addr<=i, wren<=0, go to WAIT_I.
- WAIT_I: hold for RD_LAT cycles (internal counter), then go to CAP_I.
- CAP_I: si<=rddata; j<=j+rddata+keyreg[kidx], truncated to ADDR_W bits (natural wrap, no % operator); kidx<=(kidx==KEY_BYTES-1)?0:kidx+1. Go to ISSUE_J.
- ISSUE_J: addr<=j, go to WAIT_J.
- WAIT_J: hold for RD_LAT cycles, then go to CAP_J.
- CAP_J: sj<=rddata, go to WR_J.
- WR_J: addr<=j, wrdata<=si, wren<=1, go to WR_I.
- WR_I: addr<=i, wrdata<=sj, wren<=1. If i==N-1, go to DONE; else i<=i+1 and go to ISSUE_I.
- DONE: wren<=0, addr<=0, busy<=0, done<=1. Stay until start.
- wren is high only in the cycle after the WR_J and WR_I edges, i.e. exactly 2 write cycles per iteration.
- i==j: both writes carry the same value (sj==si), so the entry is unchanged. Write order is always j then i.
- i counter is ADDR_W+1 bits wide, so N=256 terminates correctly.
- Iteration length: 6+2*RD_LAT cycles. Total run: N*(6+2*RD_LAT) cycles from the first ISSUE_I to DONE. For defaults, 2560 cycles.
- key changes during a run have no effect, because the key is latched at start.

Test Plan:
- Functional, N=4, key=0x00: ADDR_W=2, KEY_BYTES=1, RD_LAT=2, RAM preloaded [0,1,2,3], key=8'h00, start pulse -> final RAM [0,2,3,1]; done rises 40 cycles after ISSUE_I; exactly 8 wren pulses.
- Functional, key wrap: ADDR_W=2, KEY_BYTES=2, key=16'h0102, identity RAM -> final RAM [0,3,2,1]. Proves the kidx wrap and the i==j swap at i=2.
- Full-size default (ADDR_W=8, KEY_BYTES=3, RD_LAT=2): identity RAM, key=24'h000249 -> RAM matches the software RC4 KSA model; busy high for 2560 cycles; done held high until the next start.
- RD_LAT=1 and RD_LAT=4 with a RAM model of matching latency, same stimulus as the first N=4 scenario -> identical final RAM [0,2,3,1]; run lengths 32 and 56 cycles.
- start pulsed again at cycle 100 of a run -> ignored; result and cycle count unchanged. Then start from DONE with a reloaded identity RAM -> done drops next cycle and the run repeats correctly.
- rst_n asserted mid-run, during the WR_J cycle -> wren, busy and done go low asynchronously; state is IDLE; no further writes until start.

Source files
------------

// File: rtl/ksa_swap_loop_p.sv
// ---------------------------------------------------------------------------
// ksa_swap_loop_p
// RC4 key-scheduling swap loop (second KSA loop). It permutes an S-box that is
// already initialised to identity, in place, through a single-port RAM:
//   for i = 0..N-1: j = j + S[i] + key[i mod KEY_BYTES]; swap(S[i], S[j])
// Every iteration does two reads (S[i], S[j]) and two writes (j first, then i).
//
// Parameters
//   KEY_BYTES  key length in bytes (1..32)
//   ADDR_W     S-box address width, N = 2**ADDR_W entries (2..8)
//   RD_LAT     RAM read latency in cycles (1..4)
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   start_i      one-cycle run request, honoured only in IDLE or DONE
//   key_i        secret key, byte 0 in the top byte (MSB-first)
//   busy_o       high from the cycle after an accepted start until DONE
//   done_o       high in DONE, held until the next accepted start
//   addr_o       RAM address (registered)
//   rddata_i     RAM read data
//   wrdata_o     RAM write data (registered)
//   wren_o       RAM write enable (registered)
// ---------------------------------------------------------------------------
module ksa_swap_loop_p #(
    parameter int KEY_BYTES = 3,
    parameter int ADDR_W    = 8,
    parameter int RD_LAT    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic [8*KEY_BYTES-1:0] key_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [ADDR_W-1:0]      addr_o,
    input  logic [7:0]             rddata_i,
    output logic [7:0]             wrdata_o,
    output logic                   wren_o
);

    localparam int N  = 2**ADDR_W;
    // i is one bit wider than an address so that N = 256 cannot wrap early
    localparam int IW = ADDR_W + 1;
    localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

    localparam logic [IW-1:0] I_LAST = IW'(N - 1);
    localparam logic [KW-1:0] K_LAST = KW'(KEY_BYTES - 1);
    localparam logic [2:0]    W_LAST = 3'(RD_LAT - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ISSUE_I,
        S_WAIT_I,
        S_CAP_I,
        S_ISSUE_J,
        S_WAIT_J,
        S_CAP_J,
        S_WR_J,
        S_WR_I,
        S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [IW-1:0]            i_q, i_d;
    logic [ADDR_W-1:0]        j_q, j_d;
    logic [KW-1:0]            kidx_q, kidx_d;
    logic [2:0]               wcnt_q, wcnt_d;
    logic [8*KEY_BYTES-1:0]   key_q, key_d;
    logic [7:0]               si_q, si_d;
    logic [7:0]               sj_q, sj_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic [7:0]               wrdata_q, wrdata_d;
    logic                     wren_q, wren_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic [7:0]               key_byte;

    // Key byte selected by kidx; byte 0 sits in the most significant byte.
    always_comb begin
        key_byte = 8'h00;
        for (int b = 0; b < KEY_BYTES; b++) begin
            if (kidx_q == KW'(b)) key_byte = key_q[8*(KEY_BYTES-b)-1 -: 8];
        end
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start_i) state_d = S_ISSUE_I;
            S_DONE:    if (start_i) state_d = S_ISSUE_I;
            S_ISSUE_I: state_d = S_WAIT_I;
            S_WAIT_I:  if (wcnt_q == W_LAST) state_d = S_CAP_I;
            S_CAP_I:   state_d = S_ISSUE_J;
            S_ISSUE_J: state_d = S_WAIT_J;
            S_WAIT_J:  if (wcnt_q == W_LAST) state_d = S_CAP_J;
            S_CAP_J:   state_d = S_WR_J;
            S_WR_J:    state_d = S_WR_I;
            S_WR_I:    state_d = (i_q == I_LAST) ? S_DONE : S_ISSUE_I;
            default:   state_d = S_IDLE;
        endcase
    end

    // ---------------- datapath / output next-state logic ----------------
    always_comb begin
        i_d      = i_q;
        j_d      = j_q;
        kidx_d   = kidx_q;
        wcnt_d   = wcnt_q;
        key_d    = key_q;
        si_d     = si_q;
        sj_d     = sj_q;
        addr_d   = addr_q;
        wrdata_d = wrdata_q;
        wren_d   = wren_q;
        busy_d   = busy_q;
        done_d   = done_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (state_q == S_DONE) begin
                    wren_d = 1'b0;
                    addr_d = '0;
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
                // Key is latched here so later changes on key_i cannot
                // disturb a run in progress.
                if (start_i) begin
                    key_d  = key_i;
                    i_d    = '0;
                    j_d    = '0;
                    kidx_d = '0;
                    busy_d = 1'b1;
                    done_d = 1'b0;
                end
            end
            S_ISSUE_I: begin
                addr_d = i_q[ADDR_W-1:0];
                wren_d = 1'b0;
                wcnt_d = '0;
            end
            S_WAIT_I, S_WAIT_J: wcnt_d = wcnt_q + 3'd1;
            S_CAP_I: begin
                si_d   = rddata_i;
                // Sum taken at ADDR_W bits: the natural wrap is the mod N.
                j_d    = j_q + ADDR_W'(rddata_i) + ADDR_W'(key_byte);
                kidx_d = (kidx_q == K_LAST) ? '0 : kidx_q + KW'(1);
            end
            S_ISSUE_J: begin
                addr_d = j_q;
                wcnt_d = '0;
            end
            S_CAP_J: sj_d = rddata_i;
            S_WR_J: begin
                addr_d   = j_q;
                wrdata_d = si_q;
                wren_d   = 1'b1;
            end
            S_WR_I: begin
                // When i == j both writes carry the same byte, so the entry
                // is left unchanged without any special case.
                addr_d   = i_q[ADDR_W-1:0];
                wrdata_d = sj_q;
                wren_d   = 1'b1;
                if (i_q == I_LAST) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end else begin
                    i_d = i_q + IW'(1);
                end
            end
            default: ;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_q      <= '0;
            j_q      <= '0;
            kidx_q   <= '0;
            wcnt_q   <= '0;
            key_q    <= '0;
            si_q     <= '0;
            sj_q     <= '0;
            addr_q   <= '0;
            wrdata_q <= '0;
            wren_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            i_q      <= i_d;
            j_q      <= j_d;
            kidx_q   <= kidx_d;
            wcnt_q   <= wcnt_d;
            key_q    <= key_d;
            si_q     <= si_d;
            sj_q     <= sj_d;
            addr_q   <= addr_d;
            wrdata_q <= wrdata_d;
            wren_q   <= wren_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign addr_o   = addr_q;
    assign wrdata_o = wrdata_q;
    assign wren_o   = wren_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;

endmodule

// File: tb/tb_ksa_swap_loop_p.sv
// ---------------------------------------------------------------------------
// tb_ksa_swap_loop_p
// Bench for ksa_swap_loop_p. Instances 0..3 are N=4 S-boxes (RD_LAT 1, 2,
// 2 with a 2-byte key, 4); instance 4 is the full-size default. Each instance
// has its own RAM model with matching read latency. Expected final RAM images
// are queued when a run is started and drained when done is seen.
// ---------------------------------------------------------------------------
module tb_ksa_swap_loop_p;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        s_load;              // reloads every RAM model with identity
    logic        s_start [5];
    logic        s_busy  [5];
    logic        s_done  [5];
    logic        s_wren  [5];
    logic [7:0]  s_addr  [5];
    logic [31:0] s_img   [4];
    logic [23:0] b_key;

    logic [7:0]  sb_q [$];
    int          n_chk = 0;
    int          n_err = 0;

    // ---------------- small N=4 instances ----------------
    for (genvar g = 0; g < 4; g++) begin : g_s
        localparam int LAT = (g == 0) ? 1 : ((g == 3) ? 4 : 2);
        localparam int KB  = (g == 2) ? 2 : 1;
        localparam int KBW = 8 * KB;
        localparam logic [KBW-1:0] KEY = KBW'(g == 2 ? 16'h0102 : 16'h0000);

        logic [1:0] addr;
        logic [7:0] wrdata, rddata;
        logic [7:0] mem  [4];
        logic [7:0] pipe [LAT];

        ksa_swap_loop_p #(.KEY_BYTES(KB), .ADDR_W(2), .RD_LAT(LAT)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .start_i  (s_start[g]),
            .key_i    (KEY),
            .busy_o   (s_busy[g]),
            .done_o   (s_done[g]),
            .addr_o   (addr),
            .rddata_i (rddata),
            .wrdata_o (wrdata),
            .wren_o   (s_wren[g])
        );

        assign rddata = pipe[LAT-1];
        always_ff @(posedge clk) begin
            if (s_load) for (int k = 0; k < 4; k++) mem[k] <= 8'(k);
            else if (s_wren[g]) mem[addr] <= wrdata;
            pipe[0] <= mem[addr];
            for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        end
        assign s_img[g]  = {mem[0], mem[1], mem[2], mem[3]};
        assign s_addr[g] = 8'(addr);
    end

    // ---------------- full-size default instance ----------------
    logic [7:0] b_addr, b_wrdata, b_rddata;
    logic [7:0] bmem  [256];
    logic [7:0] bpipe [2];

    ksa_swap_loop_p #(.KEY_BYTES(3), .ADDR_W(8), .RD_LAT(2)) u_big (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (s_start[4]),
        .key_i    (b_key),
        .busy_o   (s_busy[4]),
        .done_o   (s_done[4]),
        .addr_o   (b_addr),
        .rddata_i (b_rddata),
        .wrdata_o (b_wrdata),
        .wren_o   (s_wren[4])
    );

    assign b_rddata  = bpipe[1];
    assign s_addr[4] = b_addr;
    always_ff @(posedge clk) begin
        if (s_load) for (int k = 0; k < 256; k++) bmem[k] <= 8'(k);
        else if (s_wren[4]) bmem[b_addr] <= b_wrdata;
        bpipe[0] <= bmem[b_addr];
        bpipe[1] <= bpipe[0];
    end

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mem_at(input int idx, input int k);
        logic [31:0] img;
        if (idx == 4) return bmem[k];
        img = s_img[idx];
        return img[8*(3-k) +: 8];
    endfunction

    task automatic push4(input logic [7:0] a, b, c, d);
        sb_q.push_back(a); sb_q.push_back(b); sb_q.push_back(c); sb_q.push_back(d);
    endtask

    // Reference RC4 KSA over an identity S-box, 3-byte key, byte 0 = MSB.
    task automatic ksa_push(input logic [23:0] key);
        logic [7:0] s [256];
        logic [7:0] t;
        int j;
        j = 0;
        for (int i = 0; i < 256; i++) s[i] = 8'(i);
        for (int i = 0; i < 256; i++) begin
            j = (j + int'(s[i]) + int'(key[8*(2-(i%3)) +: 8])) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
        end
        for (int i = 0; i < 256; i++) sb_q.push_back(s[i]);
    endtask

    // Start a run on instance idx, check handshake timing, write count and the
    // final RAM image. With mid set, a stray start at cycle 100 and a key
    // change at cycle 50 are injected; both must be ignored.
    task automatic run(input int idx, input int exp_cyc, input int exp_wr, input bit mid);
        int cyc, bc, wc, k;
        s_start[idx] = 1'b1;
        @(negedge clk);
        s_start[idx] = 1'b0;
        chk($sformatf("u%0d busy_after_start", idx), 32'(s_busy[idx]), 32'd1);
        chk($sformatf("u%0d done_after_start", idx), 32'(s_done[idx]), 32'd0);
        cyc = 0;
        bc  = s_busy[idx] ? 1 : 0;
        wc  = 0;
        while (!s_done[idx] && cyc < exp_cyc + 100) begin
            @(negedge clk);
            cyc++;
            if (s_busy[idx]) bc++;
            if (s_wren[idx]) wc++;
            s_start[idx] = mid && (cyc == 100);
            if (mid && cyc == 50) b_key = 24'hFFFFFF;
        end
        s_start[idx] = 1'b0;
        chk($sformatf("u%0d cycles_to_done", idx), 32'(cyc), 32'(exp_cyc));
        chk($sformatf("u%0d busy_cycles", idx), 32'(bc), 32'(exp_cyc));
        repeat (3) @(negedge clk);
        chk($sformatf("u%0d write_pulses", idx), 32'(wc), 32'(exp_wr));
        chk($sformatf("u%0d wren_idle", idx), 32'(s_wren[idx]), 32'd0);
        k = 0;
        while (sb_q.size() > 0) begin
            chk($sformatf("u%0d ram[%0d]", idx, k), 32'(mem_at(idx, k)), 32'(sb_q.pop_front()));
            k++;
        end
        chk($sformatf("u%0d ram_entries", idx), 32'(k), (idx == 4) ? 32'd256 : 32'd4);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int wc;
        rst_n  = 1'b0;
        s_load = 1'b1;
        b_key  = 24'h000249;
        for (int k = 0; k < 5; k++) s_start[k] = 1'b0;
        repeat (3) @(negedge clk);
        s_load = 1'b0;

        for (int k = 0; k < 5; k++) begin
            chk($sformatf("u%0d rst_busy", k), 32'(s_busy[k]), 32'd0);
            chk($sformatf("u%0d rst_done", k), 32'(s_done[k]), 32'd0);
            chk($sformatf("u%0d rst_wren", k), 32'(s_wren[k]), 32'd0);
            chk($sformatf("u%0d rst_addr", k), 32'(s_addr[k]), 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // N=4, key 0x00: RD_LAT 1, 2, 4 give the same image, 8 writes each
        push4(8'd0, 8'd2, 8'd3, 8'd1); run(0, 32, 8, 1'b0);
        push4(8'd0, 8'd2, 8'd3, 8'd1); run(1, 40, 8, 1'b0);
        // 2-byte key 0x0102 exercises the kidx wrap and the i==j case at i=2
        push4(8'd0, 8'd3, 8'd2, 8'd1); run(2, 40, 8, 1'b0);
        push4(8'd0, 8'd2, 8'd3, 8'd1); run(3, 56, 8, 1'b0);

        // Full-size run with stray start and key change mid-run
        ksa_push(24'h000249);
        run(4, 2560, 512, 1'b1);
        b_key = 24'h000249;
        repeat (20) @(negedge clk);
        chk("u4 done_held", 32'(s_done[4]), 32'd1);
        chk("u4 busy_low_in_done", 32'(s_busy[4]), 32'd0);

        // Restart from DONE on a reloaded identity RAM
        s_load = 1'b1;
        @(negedge clk);
        s_load = 1'b0;
        ksa_push(24'h000249);
        run(4, 2560, 512, 1'b0);

        // Reset during the WR_J cycle of iteration 3 (38 edges after accept)
        s_start[4] = 1'b1;
        @(negedge clk);
        s_start[4] = 1'b0;
        repeat (38) @(negedge clk);
        chk("u4 busy_before_rst", 32'(s_busy[4]), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("u4 async_busy", 32'(s_busy[4]), 32'd0);
        chk("u4 async_done", 32'(s_done[4]), 32'd0);
        chk("u4 async_wren", 32'(s_wren[4]), 32'd0);
        chk("u4 async_addr", 32'(s_addr[4]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wc = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (s_wren[4] || s_busy[4] || s_done[4]) wc++;
        end
        chk("u4 quiet_after_rst", 32'(wc), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
